ysyx_25040109_mem_arbiter: RTL



---
 rtl/ysyx_25040109_mem_arbiter.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_25040109_mem_arbiter.sv
// Merges the core's fetch and load/store channels onto one single-outstanding memory request port.
// Latency: 3 cycles from request to response pulse with zero-wait memory, 1 cycle for a rejected store.
// Backpressure: mem_req_valid is held with stable fields until mem_req_ready; the core holds its request until the pulse.
module ysyx_25040109_mem_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic        imem_ren,
  output logic [31:0] imem_rdata,
  output logic        imem_rvalid,
  input  logic [31:0] dmem_raddr,
  input  logic        dmem_ren,
  output logic [31:0] dmem_rdata,
  output logic        dmem_rvalid,
  input  logic [31:0] dmem_waddr,
  input  logic [31:0] dmem_wdata,
  input  logic [2:0]  dmem_wlen,
  input  logic        dmem_wen,
  output logic        dmem_wready,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_we,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic        err
);

  localparam logic [15:0] TimeoutW = 16'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;
  typedef enum logic [1:0] {CH_FETCH, CH_LOAD, CH_STORE} chan_e;

  state_e      state_q;
  chan_e       chan_q;
  logic        last_data_q;
  logic [15:0] cnt_q;
  logic [1:0]  off_q;
  logic        imem_rvalid_q;
  logic        dmem_rvalid_q;
  logic        dmem_wready_q;
  logic [31:0] imem_rdata_q;
  logic [31:0] dmem_rdata_q;
  logic        mem_req_valid_q;
  logic [31:0] mem_req_addr_q;
  logic        mem_req_we_q;
  logic [31:0] mem_req_wdata_q;
  logic [3:0]  mem_req_wstrb_q;
  logic        err_q;

  logic        data_req;
  logic        gnt_vld;
  chan_e       gnt_chan;
  logic [31:0] gnt_addr;

  // Pick the next channel: store beats load, data-vs-fetch ties go to whoever was not granted last.
  always_comb begin
    data_req = dmem_wen | dmem_ren;
    gnt_vld  = data_req | imem_ren;
    gnt_chan = CH_FETCH;
    if (data_req && (!imem_ren || !last_data_q)) begin
      gnt_chan = dmem_wen ? CH_STORE : CH_LOAD;
    end
    gnt_addr = imem_addr;
    if (gnt_chan == CH_LOAD) begin
      gnt_addr = dmem_raddr;
    end else if (gnt_chan == CH_STORE) begin
      gnt_addr = dmem_waddr;
    end
  end

  logic [1:0]  st_off;
  logic [3:0]  st_strb;
  logic        st_legal;
  logic [31:0] st_wdata;

  // Store lane placement and alignment legality.
  always_comb begin
    st_off   = dmem_waddr[1:0];
    st_strb  = 4'b0000;
    st_legal = 1'b0;
    case (dmem_wlen)
      3'd1: begin
        st_strb  = 4'b0001 << st_off;
        st_legal = 1'b1;
      end
      3'd2: begin
        st_strb  = 4'b0011 << st_off;
        st_legal = ~st_off[0];
      end
      3'd4: begin
        st_strb  = 4'b1111;
        st_legal = (st_off == 2'b00);
      end
      default: ;
    endcase
    st_wdata = dmem_wdata << {st_off, 3'b000};
  end

  logic [15:0] cnt_inc;
  logic        cnt_hit;
  logic        fin;
  logic        fin_tmo;
  logic [31:0] fin_rdata;

  // Transaction completion: a real response wins over the watchdog in the same cycle.
  always_comb begin
    cnt_inc = cnt_q + 16'd1;
    cnt_hit = (cnt_inc == TimeoutW);
    fin     = 1'b0;
    fin_tmo = 1'b0;
    if (state_q == S_WAIT && mem_resp_valid) begin
      fin = 1'b1;
    end else if ((state_q == S_REQ || state_q == S_WAIT) && cnt_hit) begin
      fin     = 1'b1;
      fin_tmo = 1'b1;
    end
    if (fin_tmo) begin
      fin_rdata = 32'hdeadbeef;
    end else if (chan_q == CH_LOAD) begin
      fin_rdata = mem_resp_rdata >> {off_q, 3'b000};
    end else begin
      fin_rdata = mem_resp_rdata;
    end
  end

  // Arbitration FSM; every output toward the core and the memory is registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      chan_q          <= CH_FETCH;
      last_data_q     <= 1'b0;
      cnt_q           <= '0;
      off_q           <= '0;
      imem_rvalid_q   <= 1'b0;
      dmem_rvalid_q   <= 1'b0;
      dmem_wready_q   <= 1'b0;
      imem_rdata_q    <= '0;
      dmem_rdata_q    <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_we_q    <= 1'b0;
      mem_req_wdata_q <= '0;
      mem_req_wstrb_q <= '0;
      err_q           <= 1'b0;
    end else begin
      imem_rvalid_q <= 1'b0;
      dmem_rvalid_q <= 1'b0;
      dmem_wready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (gnt_vld) begin
            chan_q      <= gnt_chan;
            last_data_q <= (gnt_chan != CH_FETCH);
            cnt_q       <= '0;
            off_q       <= gnt_addr[1:0];
            if (gnt_chan == CH_STORE && !st_legal) begin
              // Rejected store: no memory access, complete immediately with an error.
              err_q         <= 1'b1;
              dmem_wready_q <= 1'b1;
              state_q       <= S_RESP;
            end else begin
              mem_req_valid_q <= 1'b1;
              mem_req_addr_q  <= {gnt_addr[31:2], 2'b00};
              mem_req_we_q    <= (gnt_chan == CH_STORE);
              mem_req_wstrb_q <= (gnt_chan == CH_STORE) ? st_strb : 4'b0000;
              mem_req_wdata_q <= (gnt_chan == CH_STORE) ? st_wdata : 32'h0;
              state_q         <= S_REQ;
            end
          end
        end
        S_REQ, S_WAIT: begin
          cnt_q <= cnt_inc;
          if (fin) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= S_RESP;
            if (fin_tmo) begin
              err_q <= 1'b1;
            end
            case (chan_q)
              CH_FETCH: begin
                imem_rvalid_q <= 1'b1;
                imem_rdata_q  <= fin_rdata;
              end
              CH_LOAD: begin
                dmem_rvalid_q <= 1'b1;
                dmem_rdata_q  <= fin_rdata;
              end
              default: dmem_wready_q <= 1'b1;
            endcase
          end else if (state_q == S_REQ && mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= S_WAIT;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_rvalid   = imem_rvalid_q;
  assign imem_rdata    = imem_rdata_q;
  assign dmem_rvalid   = dmem_rvalid_q;
  assign dmem_rdata    = dmem_rdata_q;
  assign dmem_wready   = dmem_wready_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_we    = mem_req_we_q;
  assign mem_req_wdata = mem_req_wdata_q;
  assign mem_req_wstrb = mem_req_wstrb_q;
  assign err           = err_q;

endmodule
